// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory block-copy engine.
package mem_copy_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 9;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy initiator: moves len bytes src->dst, one byte per read/write cycle pair.
// Build option COPY_CHECKSUM_EN adds a running mod-2**DW sum of the copied bytes.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  copy_state_t   state, state_nx;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] len_q, count;
  logic [DW-1:0] data_q;
  logic          aborted_q;
  logic          accept;
  logic          last_byte;

  assign accept    = (state == IDLE) && start;
  assign last_byte = (count + LW'(1)) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : READ;
      READ:    state_nx = abort ? DONE : WRITE;
      WRITE:   state_nx = (last_byte || abort) ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode from state alone, so an async reset drops mem_wr_en at once.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      READ: begin
        busy     = 1'b1;
        mem_addr = src_q + count[AW-1:0];
      end
      WRITE: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = dst_q + count[AW-1:0];
        mem_wdata = data_q;
      end
      DONE: begin
        done    = 1'b1;
        aborted = aborted_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      aborted_q <= 1'b0;
    end else if (accept) begin
      count     <= '0;
      aborted_q <= 1'b0;
    end else if (state == READ) begin
      if (abort) aborted_q <= 1'b1;
    end else if (state == WRITE) begin
      count <= count + LW'(1);
      if (abort) aborted_q <= 1'b1;
    end
  end

  // Operands and the byte in flight carry no reset; they are only used after an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_q <= src;
      dst_q <= dst;
      len_q <= len;
    end
    if (state == READ) data_q <= mem_rdata;
  end

`ifdef COPY_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              checksum <= '0;
    else if (accept)         checksum <= '0;
    else if (state == WRITE) checksum <= checksum + data_q;
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine with a behavioural 256x8 memory and read/write scoreboard.
module tb_mem_copy_engine;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, aborted, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
  logic [DW-1:0] cs_at_done;
`endif

  mem_copy_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef COPY_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en)   mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  logic outs_any;
`ifdef COPY_CHECKSUM_EN
  assign outs_any = |{busy, done, aborted, mem_wr_en, mem_addr, mem_wdata, checksum};
`else
  assign outs_any = |{busy, done, aborted, mem_wr_en, mem_addr, mem_wdata};
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  wr_t        mon_w;
  logic [7:0] mon_r;

  // Scoreboard: every write and every read address the DUT issues is matched in order.
  always @(negedge clk) begin
    if (rst_n && mem_wr_en) begin
      checks++;
      if (exp_wr.size() == 0 || !busy) begin
        errors++;
        $display("FAIL write_seq: unexpected write addr=%0d data=%0d busy=%0b", mem_addr, mem_wdata, busy);
      end else begin
        mon_w = exp_wr.pop_front();
        if ({mem_addr, mem_wdata} !== mon_w) begin
          errors++;
          $display("FAIL write_seq: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   mem_addr, mem_wdata, mon_w.addr, mon_w.data);
        end
      end
    end else if (rst_n && busy) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL read_seq: unexpected read addr=%0d", mem_addr);
      end else begin
        mon_r = exp_rd.pop_front();
        if (mem_addr !== mon_r) begin
          errors++;
          $display("FAIL read_seq: got addr=%0d, expected addr=%0d", mem_addr, mon_r);
        end
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] ar, aw;
    for (int i = 0; i < n; i++) begin
      ar = s + 8'(i);
      aw = d + 8'(i);
      exp_rd.push_back(ar);
      exp_wr.push_back({aw, ref_mem[ar]});
      ref_mem[aw] = ref_mem[ar];
    end
  endtask

  task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [LW-1:0] l,
                         input int abort_at, input bit glitch, input bit start_abort,
                         output int cyc, output bit ab, output bit saw_busy, output bit saw_wr);
    int  nwr;
    bit  fin;
    @(posedge clk); #1;
    src = s; dst = d; len = l; start = 1'b1; abort = start_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; src = ~s; dst = ~d; len = l + 9'd3;
    cyc = 0; nwr = 0; fin = 1'b0; ab = 1'b0; saw_busy = 1'b0; saw_wr = 1'b0;
    while (!fin && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (busy) saw_busy = 1'b1;
      if (mem_wr_en) begin
        saw_wr = 1'b1;
        nwr++;
        if (abort_at != 0 && nwr == abort_at) abort = 1'b1;
      end
      if (glitch && cyc == 3) begin
        start = 1'b1; src = 8'h05; dst = 8'h06; len = 9'd2;
      end
      if (glitch && cyc == 4) start = 1'b0;
      if (done) begin
        fin = 1'b1;
        ab  = aborted;
`ifdef COPY_CHECKSUM_EN
        cs_at_done = checksum;
`endif
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: got %0b, expected 0", busy);
        end
      end
    end
    abort = 1'b0;
    start = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, expected one", cyc);
    end
  endtask

  task automatic check_queues(input string name);
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: writes left=%0d reads left=%0d, expected 0/0", name, exp_wr.size(), exp_rd.size());
    end
    exp_wr.delete();
    exp_rd.delete();
  endtask

  task automatic check_image(input string name);
    int diffs;
    int first;
    diffs = 0; first = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) begin
        diffs++;
        if (first < 0) first = i;
      end
    checks++;
    if (diffs != 0) begin
      errors++;
      $display("FAIL %s_image: %0d bytes differ, first at %0d got %0d expected %0d",
               name, diffs, first, mem[first], ref_mem[first]);
    end
  endtask

  task automatic check_copy(input string name, input int cyc, input int cyc_exp, input bit ab, input bit ab_exp);
    checks++;
    if (cyc !== cyc_exp) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc, cyc_exp);
    end
    checks++;
    if (ab !== ab_exp) begin
      errors++;
      $display("FAIL %s_aborted: got %0b, expected %0b", name, ab, ab_exp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    @(negedge clk);
    checks++;
    if (outs_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero (busy=%0b done=%0b addr=%0d), expected all 0", busy, done, mem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_any !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: some output nonzero after reset release, expected all 0");
    end
  endtask

  task automatic test_basic();
    int cyc; bit ab, sb, sw;
    poke(8'd16, 8'd11); poke(8'd17, 8'd22); poke(8'd18, 8'd33); poke(8'd19, 8'd44);
    push_copy(8'd16, 8'd96, 4);
    do_copy(8'd16, 8'd96, 9'd4, 0, 1'b0, 1'b1, cyc, ab, sb, sw);
    check_copy("basic", cyc, 9, ab, 1'b0);
    check_queues("basic");
    check_image("basic");
    checks++;
    if ({mem[96], mem[97], mem[98], mem[99]} !== {8'd11, 8'd22, 8'd33, 8'd44}) begin
      errors++;
      $display("FAIL basic_bytes: got %0d,%0d,%0d,%0d expected 11,22,33,44", mem[96], mem[97], mem[98], mem[99]);
    end
  endtask

  task automatic test_zero_len();
    int cyc; bit ab, sb, sw;
    do_copy(8'd30, 8'd130, 9'd0, 0, 1'b0, 1'b0, cyc, ab, sb, sw);
    check_copy("zero_len", cyc, 1, ab, 1'b0);
    checks++;
    if (sw !== 1'b0 || sb !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_activity: wr_en_seen=%0b busy_seen=%0b, expected 0/0", sw, sb);
    end
    check_queues("zero_len");
  endtask

  task automatic test_wrap();
    int cyc; bit ab, sb, sw;
    poke(8'd254, 8'hA1); poke(8'd255, 8'hB2); poke(8'd0, 8'hC3); poke(8'd1, 8'hD4);
    push_copy(8'd254, 8'd1, 4);
    do_copy(8'd254, 8'd1, 9'd4, 0, 1'b0, 1'b0, cyc, ab, sb, sw);
    check_copy("wrap", cyc, 9, ab, 1'b0);
    check_queues("wrap");
    check_image("wrap");
    checks++;
    if ({mem[1], mem[2], mem[3], mem[4]} !== {8'hA1, 8'hB2, 8'hC3, 8'hA1}) begin
      errors++;
      $display("FAIL wrap_overlap: got %h,%h,%h,%h expected a1,b2,c3,a1", mem[1], mem[2], mem[3], mem[4]);
    end
  endtask

  task automatic test_abort();
    int cyc; bit ab, sb, sw;
    for (int i = 0; i < 8; i++) poke(8'(32 + i), 8'(i * 7 + 100));
    push_copy(8'd32, 8'd200, 3);
    do_copy(8'd32, 8'd200, 9'd8, 3, 1'b0, 1'b0, cyc, ab, sb, sw);
    check_copy("abort", cyc, 7, ab, 1'b1);
    check_queues("abort");
    check_image("abort");
  endtask

  task automatic test_reset_midcopy();
    int cyc; bit ab, sb, sw;
    poke(8'd60, 8'd1); poke(8'd61, 8'd2); poke(8'd62, 8'd3); poke(8'd63, 8'd4);
    exp_rd.push_back(8'd60);
    exp_rd.push_back(8'd61);
    exp_wr.push_back({8'd160, ref_mem[60]});
    ref_mem[160] = ref_mem[60];
    @(posedge clk); #1;
    src = 8'd60; dst = 8'd160; len = 9'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mem_wr_en, mem_addr} !== {1'b1, 1'b0, 8'd61}) begin
      errors++;
      $display("FAIL midcopy_state: busy=%0b wr_en=%0b addr=%0d, expected 1/0/61", busy, mem_wr_en, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs_any !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b wr_en=%0b addr=%0d, expected all outputs 0", busy, mem_wr_en, mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (outs_any !== 1'b0) begin
      errors++;
      $display("FAIL held_reset: busy=%0b wr_en=%0b addr=%0d, expected all outputs 0", busy, mem_wr_en, mem_addr);
    end
    rst_n = 1'b1;
    check_queues("midcopy");
    push_copy(8'd60, 8'd170, 4);
    do_copy(8'd60, 8'd170, 9'd4, 0, 1'b0, 1'b0, cyc, ab, sb, sw);
    check_copy("after_reset", cyc, 9, ab, 1'b0);
    check_queues("after_reset");
    check_image("after_reset");
  endtask

  task automatic test_back_to_back();
    int cyc; bit ab, sb, sw;
    push_copy(8'd70, 8'd180, 5);
    do_copy(8'd70, 8'd180, 9'd5, 0, 1'b1, 1'b0, cyc, ab, sb, sw);
    check_copy("busy_start", cyc, 11, ab, 1'b0);
    push_copy(8'd180, 8'd90, 2);
    do_copy(8'd180, 8'd90, 9'd2, 0, 1'b0, 1'b0, cyc, ab, sb, sw);
    check_copy("back_to_back", cyc, 5, ab, 1'b0);
    check_queues("back_to_back");
    check_image("back_to_back");
  endtask

`ifdef COPY_CHECKSUM_EN
  task automatic test_checksum();
    int cyc; bit ab, sb, sw;
    poke(8'd40, 8'd5); poke(8'd41, 8'd250); poke(8'd42, 8'd3);
    push_copy(8'd40, 8'd140, 3);
    do_copy(8'd40, 8'd140, 9'd3, 0, 1'b1, 1'b0, cyc, ab, sb, sw);
    check_copy("checksum", cyc, 7, ab, 1'b0);
    checks++;
    if (cs_at_done !== 8'h02) begin
      errors++;
      $display("FAIL checksum_done: got %h, expected 02", cs_at_done);
    end
    @(negedge clk);
    checks++;
    if (checksum !== 8'h02) begin
      errors++;
      $display("FAIL checksum_hold: got %h, expected 02", checksum);
    end
    check_queues("checksum");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_abort();
    test_reset_midcopy();
    test_back_to_back();
`ifdef COPY_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
